// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag RX slot scheduler: FSM state encoding and
// default dwell/sync-timeout cycle counts.
package tag_anc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_DWELL     = 3'd3,
        ST_NEXT      = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_e;

    localparam int DWELL_N_DEF        = 327680;
    localparam int SYNC_TIMEOUT_N_DEF = 1048576;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change,
// so a level held high never produces a second event.
module edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_prev <= 1'b0;
        end else begin
            din_prev <= din;
        end
    end

    assign rise = din & ~din_prev;

endmodule

// File: rtl/tag_rx_slot_sched.sv
// Frequency-hop slot scheduler for the tag RX core: walks NSLOT table entries
// per frame, restarting the core per slot and gating rx_valid for a fixed dwell.
module tag_rx_slot_sched
    import tag_anc_pkg::*;
#(
    parameter int PHASE_WIDTH    = 24,
    parameter int NSLOT          = 4,
    parameter int CNT_WIDTH      = 24,
    parameter int DWELL_N        = DWELL_N_DEF,
    parameter int SYNC_TIMEOUT_N = SYNC_TIMEOUT_N_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trig,
    input  logic                     abort,
    input  logic                     cfg_we,
    input  logic [$clog2(NSLOT)-1:0] cfg_addr,
    input  logic [PHASE_WIDTH-1:0]   cfg_ph_inc,
    input  logic                     sync_ready,
    output logic                     core_srst,
    output logic [PHASE_WIDTH-1:0]   core_ph_inc,
    output logic                     rx_valid,
    output logic [$clog2(NSLOT)-1:0] slot_idx,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err,
    output logic [2:0]               state
);

    localparam int SLOT_W = $clog2(NSLOT);
    localparam logic [SLOT_W-1:0]    SLOT_LAST  = SLOT_W'(NSLOT - 1);
    localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_N - 1);
    localparam logic [CNT_WIDTH-1:0] SYNC_LAST  = CNT_WIDTH'(SYNC_TIMEOUT_N - 1);

    sched_state_e           st;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [SLOT_W-1:0]      slot_nxt;
    logic                   trig_rise;
    logic                   sync_rise;
    logic [PHASE_WIDTH-1:0] slot_tbl [NSLOT];

    edge_det u_trig_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (trig),
        .rise    (trig_rise)
    );

    edge_det u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync_ready),
        .rise    (sync_rise)
    );

    // Table is writable at any time; the core only sees an entry when ARM latches it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            slot_tbl[cfg_addr] <= cfg_ph_inc;
        end
    end

    always_comb begin
        cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
        slot_nxt = slot_idx + SLOT_W'(1);
    end

    // Outputs are set on the transition into the state they belong to, so each
    // registered output lines up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= ST_IDLE;
            cnt         <= '0;
            slot_idx    <= '0;
            core_srst   <= 1'b0;
            core_ph_inc <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            core_srst  <= 1'b0;
            frame_done <= 1'b0;
            if (abort) begin
                st       <= ST_IDLE;
                cnt      <= '0;
                slot_idx <= '0;
                rx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (trig_rise) begin
                            st          <= ST_ARM;
                            slot_idx    <= '0;
                            timeout_err <= 1'b0;
                            busy        <= 1'b1;
                            core_srst   <= 1'b1;
                            core_ph_inc <= slot_tbl[0];
                        end
                    end
                    ST_ARM: begin
                        st  <= ST_WAIT_SYNC;
                        cnt <= '0;
                    end
                    ST_WAIT_SYNC: begin
                        if (sync_rise) begin
                            st       <= ST_DWELL;
                            cnt      <= '0;
                            rx_valid <= 1'b1;
                        end else if (cnt == SYNC_LAST) begin
                            st          <= ST_IDLE;
                            cnt         <= '0;
                            slot_idx    <= '0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_DWELL: begin
                        if (cnt == DWELL_LAST) begin
                            st       <= ST_NEXT;
                            cnt      <= '0;
                            rx_valid <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_NEXT: begin
                        if (slot_idx == SLOT_LAST) begin
                            st         <= ST_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            st          <= ST_ARM;
                            slot_idx    <= slot_nxt;
                            core_srst   <= 1'b1;
                            core_ph_inc <= slot_tbl[slot_nxt];
                        end
                    end
                    ST_DONE: begin
                        st       <= ST_IDLE;
                        slot_idx <= '0;
                        busy     <= 1'b0;
                    end
                    default: begin
                        st       <= ST_IDLE;
                        cnt      <= '0;
                        slot_idx <= '0;
                        rx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_tag_rx_slot_sched.sv
// Directed bench for tag_rx_slot_sched with a short dwell and sync timeout so
// full frames, timeouts, aborts and mid-frame resets fit in a few hundred cycles.
module tb_tag_rx_slot_sched;

    localparam int PW  = 24;
    localparam int NS  = 4;
    localparam int CW  = 24;
    localparam int DW  = 16;
    localparam int STO = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          trig;
    logic          abort;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [PW-1:0] cfg_ph_inc;
    logic          sync_ready;
    logic          core_srst;
    logic [PW-1:0] core_ph_inc;
    logic          rx_valid;
    logic [1:0]    slot_idx;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [2:0]    state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int srst_cnt  = 0;
    int fd_cnt    = 0;
    int srst_wide = 0;
    logic srst_prev = 1'b0;

    logic [PW-1:0] exp_ph [NS];

    tag_rx_slot_sched #(
        .PHASE_WIDTH    (PW),
        .NSLOT          (NS),
        .CNT_WIDTH      (CW),
        .DWELL_N        (DW),
        .SYNC_TIMEOUT_N (STO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .trig        (trig),
        .abort       (abort),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_ph_inc  (cfg_ph_inc),
        .sync_ready  (sync_ready),
        .core_srst   (core_srst),
        .core_ph_inc (core_ph_inc),
        .rx_valid    (rx_valid),
        .slot_idx    (slot_idx),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .state       (state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Event counters sampled on the falling edge
    always @(negedge clk) begin
        if (core_srst) srst_cnt++;
        if (frame_done) fd_cnt++;
        if (core_srst && srst_prev) srst_wide++;
        srst_prev = core_srst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [PW-1:0] data);
        cfg_we     = 1'b1;
        cfg_addr   = addr;
        cfg_ph_inc = data;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Waits for the slot's restart pulse, then answers with a sync pulse 5 cycles later.
    task automatic start_slot(input int s, input logic [PW-1:0] ph);
        int n = 0;
        while (!core_srst && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("srst_seen_s%0d", s), 32'(core_srst), 32'd1);
        check($sformatf("slot_idx_s%0d", s), 32'(slot_idx), 32'(s));
        check($sformatf("ph_inc_s%0d", s), 32'(core_ph_inc), 32'(ph));
        repeat (5) tick();
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
        check($sformatf("dwell_entry_s%0d", s), 32'(state), 32'd3);
    endtask

    task automatic finish_slot(input int s, input int n_exp, input bit last);
        int n = 0;
        while (rx_valid && n < 100) begin
            n++;
            tick();
        end
        check($sformatf("rx_valid_len_s%0d", s), 32'(n), 32'(n_exp));
        check($sformatf("next_state_s%0d", s), 32'(state), 32'd4);
        tick();
        if (last) begin
            check("done_state", 32'(state), 32'd5);
            check("done_pulse", 32'(frame_done), 32'd1);
            tick();
            check("done_to_idle", 32'(state), 32'd0);
            check("done_slot_zero", 32'(slot_idx), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_pulse_end", 32'(frame_done), 32'd0);
        end
    endtask

    initial begin
        int srst_base;
        int fd_base;

        reset_n    = 1'b0;
        trig       = 1'b0;
        abort      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_ph_inc = '0;
        sync_ready = 1'b0;
        exp_ph[0]  = 24'h000100;
        exp_ph[1]  = 24'h000200;
        exp_ph[2]  = 24'h000300;
        exp_ph[3]  = 24'h000400;

        // Reset state
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_srst", 32'(core_srst), 32'd0);
        check("rst_ph_inc", 32'(core_ph_inc), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_slot_idx", 32'(slot_idx), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NS; i++) cfg_write(2'(i), exp_ph[i]);

        // Full four-slot frame
        srst_base = srst_cnt;
        fd_base   = fd_cnt;
        pulse_trig();
        check("arm_state", 32'(state), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        for (int s = 0; s < NS; s++) begin
            start_slot(s, exp_ph[s]);
            finish_slot(s, DW, s == NS - 1);
        end
        check("frame_srst_count", 32'(srst_cnt - srst_base), 32'd4);
        check("frame_done_count", 32'(fd_cnt - fd_base), 32'd1);
        check("srst_single_cycle", 32'(srst_wide), 32'd0);

        // Sync timeout
        fd_base = fd_cnt;
        pulse_trig();
        repeat (32) tick();
        check("to_still_waiting", 32'(state), 32'd2);
        tick();
        check("to_idle", 32'(state), 32'd0);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_done", 32'(fd_cnt - fd_base), 32'd0);
        pulse_trig();
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        check("to_rearm", 32'(state), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_abort_idle", 32'(state), 32'd0);

        // Abort during slot 2 dwell
        fd_base = fd_cnt;
        pulse_trig();
        for (int s = 0; s < 2; s++) begin
            start_slot(s, exp_ph[s]);
            finish_slot(s, DW, 1'b0);
        end
        start_slot(2, exp_ph[2]);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_srst", 32'(core_srst), 32'd0);
        repeat (20) tick();
        check("abort_no_done", 32'(fd_cnt - fd_base), 32'd0);

        // Table write to the active slot during its dwell
        pulse_trig();
        start_slot(0, exp_ph[0]);
        finish_slot(0, DW, 1'b0);
        start_slot(1, exp_ph[1]);
        cfg_write(2'd1, 24'h0ABCDE);
        check("wr_ph_hold", 32'(core_ph_inc), 32'h000200);
        finish_slot(1, DW - 1, 1'b0);
        for (int s = 2; s < NS; s++) begin
            start_slot(s, exp_ph[s]);
            finish_slot(s, DW, s == NS - 1);
        end
        exp_ph[1] = 24'h0ABCDE;
        pulse_trig();
        for (int s = 0; s < NS; s++) begin
            start_slot(s, exp_ph[s]);
            finish_slot(s, DW, s == NS - 1);
        end

        // Trig re-pulse while busy, sync_ready held high across ARM
        sync_ready = 1'b1;
        repeat (2) tick();
        pulse_trig();
        check("held_arm", 32'(state), 32'd1);
        tick();
        check("held_wait", 32'(state), 32'd2);
        srst_base = srst_cnt;
        pulse_trig();
        check("retrig_ignored", 32'(state), 32'd2);
        check("retrig_slot", 32'(slot_idx), 32'd0);
        repeat (10) tick();
        check("held_no_dwell", 32'(state), 32'd2);
        check("retrig_no_srst", 32'(srst_cnt - srst_base), 32'd0);
        sync_ready = 1'b0;
        tick();
        sync_ready = 1'b1;
        tick();
        sync_ready = 1'b0;
        check("fresh_rise_dwell", 32'(state), 32'd3);
        check("fresh_rise_rx", 32'(rx_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset mid-dwell
        pulse_trig();
        start_slot(0, exp_ph[0]);
        repeat (4) tick();
        fd_base = fd_cnt;
        reset_n = 1'b0;
        #2;
        check("ar_state", 32'(state), 32'd0);
        check("ar_rx_valid", 32'(rx_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ph_inc", 32'(core_ph_inc), 32'd0);
        check("ar_slot_idx", 32'(slot_idx), 32'd0);
        check("ar_srst", 32'(core_srst), 32'd0);
        check("ar_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("ar_no_done", 32'(fd_cnt - fd_base), 32'd0);
        check("ar_idle_after", 32'(state), 32'd0);
        pulse_trig();
        check("ar_table_cleared", 32'(core_ph_inc), 32'd0);
        check("ar_rearm_srst", 32'(core_srst), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tag_rx_slot_sched.md
TAG_RX_SLOT_SCHED -- requirements
Module: tag_rx_slot_sched

Interface
REQ-001 Parameter PHASE_WIDTH, 24, width of the phase-increment word handed to the tag RX core.
REQ-002 Parameter NSLOT, 4, number of hop slots per frame (power of two, 2..16).
REQ-003 Parameter CNT_WIDTH, 24, width of the dwell and timeout counters.
REQ-004 Parameter DWELL_N, 327680, cycles of valid reception per slot after sync.
REQ-005 Parameter SYNC_TIMEOUT_N, 1048576, max cycles to wait for sync_ready per slot.
REQ-006 Ports: clk in 1 system clock; reset_n in 1 reset, asynchronous, active-low.
REQ-007 Ports: trig in 1 frame start, level from GPIO sync input; abort in 1 synchronous frame cancel.
REQ-008 Ports: cfg_we in 1, cfg_addr in log2(NSLOT), cfg_ph_inc in PHASE_WIDTH: slot table write port.
REQ-009 Ports: sync_ready in 1 from tag RX core.
REQ-010 Ports: core_srst out 1, core_ph_inc out PHASE_WIDTH: restart pulse and per-slot start phase increment to core.
REQ-011 Ports: rx_valid out 1, slot_idx out log2(NSLOT), busy out 1, frame_done out 1, timeout_err out 1, state out 3.

Function
REQ-012 Slot table SHALL hold NSLOT registers of PHASE_WIDTH; cfg_we writes cfg_ph_inc at cfg_addr next edge, in any state.
REQ-013 trig and sync_ready SHALL be rising-edge detected (registered previous value); levels never re-trigger.
REQ-014 FSM states SHALL be IDLE(0), ARM(1), WAIT_SYNC(2), DWELL(3), NEXT(4), DONE(5); state output shows the encoding.
REQ-015 IDLE: trig rise -> ARM with slot_idx=0, timeout_err cleared; otherwise hold.
REQ-016 ARM (1 cycle): core_ph_inc latched from table[slot_idx]; core_srst=1 this cycle only; counter cleared; -> WAIT_SYNC.
REQ-017 WAIT_SYNC: counter increments each cycle; sync_ready rise -> DWELL, counter cleared; counter reaching SYNC_TIMEOUT_N-1 without rise -> IDLE with timeout_err set (sticky until next trig rise).
REQ-018 DWELL: rx_valid=1; counter increments; at count DWELL_N-1 -> NEXT; dwell length exactly DWELL_N cycles.
REQ-019 NEXT (1 cycle): slot_idx==NSLOT-1 -> DONE; else slot_idx+1 -> ARM.
REQ-020 DONE (1 cycle): frame_done=1 for exactly this cycle; -> IDLE; slot_idx returns to 0.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 trig rise while busy SHALL be ignored (no restart, no queueing).
REQ-023 abort SHALL have priority over all transitions: any state -> IDLE next edge, rx_valid/core_srst deasserted, no frame_done, timeout_err unchanged.
REQ-024 Table write to the active slot during WAIT_SYNC/DWELL SHALL NOT change core_ph_inc until the next ARM of that slot.
REQ-025 sync_ready rise in ARM or DWELL SHALL be ignored; sync_ready held high from before ARM does not count as a rise.
REQ-026 Counter SHALL saturate, never wrap; all outputs registered.

Reset
REQ-027 On reset_n low: state IDLE, slot_idx 0, counter 0, core_srst 0, rx_valid 0, busy 0, frame_done 0, timeout_err 0, core_ph_inc 0, edge registers 0, table entries 0.
REQ-028 Reset mid-frame SHALL abandon the frame immediately; no frame_done after release.

Structure
REQ-029 State encoding and default DWELL_N/SYNC_TIMEOUT_N SHALL live in shared package tag_anc_pkg.
REQ-030 Edge detection SHALL be one reusable sub-module edge_det, instantiated for trig and sync_ready.

Verification
REQ-031 NSLOT=4, DWELL_N=16, table {0x000100,0x000200,0x000300,0x000400}, trig rise, sync_ready pulse 5 cycles after each srst -> 4 srst pulses, core_ph_inc 0x000100..0x000400 in order, rx_valid 16 cycles per slot, one frame_done.
REQ-032 SYNC_TIMEOUT_N=32, no sync_ready -> IDLE after 32 WAIT_SYNC cycles, timeout_err=1, no frame_done; next trig clears timeout_err.
REQ-033 abort in DWELL of slot 2 -> IDLE next cycle, rx_valid=0, busy=0, no frame_done.
REQ-034 Write 0x0ABCDE to slot 1 during slot 1 DWELL -> core_ph_inc unchanged; next frame slot 1 uses 0x0ABCDE.
REQ-035 trig re-pulsed during WAIT_SYNC and sync_ready held high across ARM -> no restart, no premature DWELL.
REQ-036 reset_n low mid-DWELL -> all outputs at REQ-027 values asynchronously; no frame_done after release.
